// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared channel indices and sizing helpers for the sharpening front-end
package pipeline_pkg;
  typedef enum logic [1:0] {CH_R, CH_G, CH_B} chan_e;
  localparam int NUM_CH = 3;
  function automatic int pix_w(input int w);
    return NUM_CH * w;
  endfunction
  function automatic int num_pixels(input int w, input int h);
    return w * h;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chan_slot.sv
// chan_slot: one-entry {data,last} holding register with valid/ready handshake
module chan_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         last_in,
  input  logic         ready,
  output logic [W-1:0] data_out,
  output logic         valid,
  output logic         last,
  output logic         slot_free,
  output logic         done_hs
);
  logic [W-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d;
  always_comb begin
    valid_d = load | (valid_q & ~ready);
    data_d  = load ? data_in : data_q;
    last_d  = load ? last_in : last_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
  assign data_out  = data_q;
  assign valid     = valid_q;
  assign last      = last_q;
  assign slot_free = ~valid_q | ready;
  assign done_hs   = valid_q & ready & last_q;
endmodule

// File: rtl/rgb_to_channels.sv
// rgb_to_channels: fork packed RGB pixels into three independently drained channel streams
module rgb_to_channels
  import pipeline_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IMG_W     = 512,
  parameter int IMG_H     = 512,
  parameter bit BGR_ORDER = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3*WIDTH-1:0]      pixel_in,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  output logic [WIDTH-1:0]        r_data_out,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic                    r_last,
  output logic [WIDTH-1:0]        g_data_out,
  output logic                    g_valid,
  input  logic                    g_ready,
  output logic                    g_last,
  output logic [WIDTH-1:0]        b_data_out,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic                    b_last,
  output logic                    frame_done
);
  localparam int PIX_W      = pix_w(WIDTH);
  localparam int NUM_PIXELS = num_pixels(IMG_W, IMG_H);
  localparam int CNT_W      = cnt_w(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);
  logic [WIDTH-1:0] ch_in [NUM_CH];
  logic [WIDTH-1:0] ch_out [NUM_CH];
  logic [NUM_CH-1:0] ch_ready, ch_valid, ch_last, slot_free, hs;
  logic [NUM_CH-1:0] done_q, done_d, done_all;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic frame_done_q, frame_done_d, accept, at_last;
  assign ch_in[CH_R] = BGR_ORDER ? pixel_in[WIDTH-1:0] : pixel_in[PIX_W-1:2*WIDTH];
  assign ch_in[CH_G] = pixel_in[2*WIDTH-1:WIDTH];
  assign ch_in[CH_B] = BGR_ORDER ? pixel_in[PIX_W-1:2*WIDTH] : pixel_in[WIDTH-1:0];
  assign ch_ready    = {b_ready, g_ready, r_ready};
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    chan_slot #(.W(WIDTH)) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (accept),
      .data_in   (ch_in[i]),
      .last_in   (at_last),
      .ready     (ch_ready[i]),
      .data_out  (ch_out[i]),
      .valid     (ch_valid[i]),
      .last      (ch_last[i]),
      .slot_free (slot_free[i]),
      .done_hs   (hs[i])
    );
  end
  assign pixel_ready = &slot_free;
  assign accept      = pixel_valid & pixel_ready;
  assign at_last     = cnt_q == LAST_IDX;
  always_comb begin
    cnt_d        = accept ? (at_last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    done_all     = done_q | hs;
    frame_done_d = &done_all;
    done_d       = frame_done_d ? '0 : done_all;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      done_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign r_data_out = ch_out[CH_R];
  assign g_data_out = ch_out[CH_G];
  assign b_data_out = ch_out[CH_B];
  assign r_valid    = ch_valid[CH_R];
  assign g_valid    = ch_valid[CH_G];
  assign b_valid    = ch_valid[CH_B];
  assign r_last     = ch_last[CH_R];
  assign g_last     = ch_last[CH_G];
  assign b_last     = ch_last[CH_B];
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_rgb_to_channels.sv
// tb_rgb_to_channels: scoreboard bench for the RGB splitter on a 4x2 frame
module tb_rgb_to_channels;
  localparam int NPIX = 8;
  typedef logic [8:0] beat_t;
  logic clk = 1'b0;
  logic reset_n;
  logic [23:0] pix;
  logic pv, rr, gr, br;
  logic pixel_ready, r_valid, g_valid, b_valid, r_last, g_last, b_last, frame_done;
  logic [7:0] r_data_out, g_data_out, b_data_out;
  logic x_ready, x_rv, x_gv, x_bv, x_rl, x_gl, x_bl, x_fd;
  logic [7:0] x_r, x_g, x_b;
  beat_t sq [3][$];
  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int exp_cnt = 0;
  int sent, base;
  always #5 clk = ~clk;
  rgb_to_channels #(.WIDTH(8), .IMG_W(4), .IMG_H(2), .BGR_ORDER(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_in(pix), .pixel_valid(pv), .pixel_ready(pixel_ready),
    .r_data_out(r_data_out), .r_valid(r_valid), .r_ready(rr), .r_last(r_last),
    .g_data_out(g_data_out), .g_valid(g_valid), .g_ready(gr), .g_last(g_last),
    .b_data_out(b_data_out), .b_valid(b_valid), .b_ready(br), .b_last(b_last),
    .frame_done(frame_done)
  );
  rgb_to_channels #(.WIDTH(8), .IMG_W(4), .IMG_H(2), .BGR_ORDER(1'b1)) dut_bgr (
    .clk(clk), .reset_n(reset_n), .pixel_in(pix), .pixel_valid(pv), .pixel_ready(x_ready),
    .r_data_out(x_r), .r_valid(x_rv), .r_ready(rr), .r_last(x_rl),
    .g_data_out(x_g), .g_valid(x_gv), .g_ready(gr), .g_last(x_gl),
    .b_data_out(x_b), .b_valid(x_bv), .b_ready(br), .b_last(x_bl),
    .frame_done(x_fd)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic mon_ch(input int c, input logic v, input logic rdy, input logic [7:0] d, input logic l, input string nm);
    beat_t e;
    if (v && rdy) begin
      if (sq[c].size() == 0) chk({nm, "_queue_depth"}, sq[c].size(), 1);
      else begin
        e = sq[c].pop_front();
        chk({nm, "_data"}, d, e[7:0]);
        chk({nm, "_last"}, l, e[8]);
      end
    end
  endtask
  task automatic chk_idle(input string t);
    chk({t, "_r_valid"}, r_valid, 0);
    chk({t, "_g_valid"}, g_valid, 0);
    chk({t, "_b_valid"}, b_valid, 0);
    chk({t, "_r_data"}, r_data_out, 0);
    chk({t, "_g_data"}, g_data_out, 0);
    chk({t, "_b_data"}, b_data_out, 0);
    chk({t, "_r_last"}, r_last, 0);
    chk({t, "_g_last"}, g_last, 0);
    chk({t, "_b_last"}, b_last, 0);
    chk({t, "_frame_done"}, frame_done, 0);
  endtask
  function automatic logic [23:0] pat(input int i);
    return {8'(3 * i + 1), 8'(3 * i + 2), 8'(3 * i + 3)};
  endfunction
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (frame_done) fd_cnt++;
      mon_ch(0, r_valid, rr, r_data_out, r_last, "sb_r");
      mon_ch(1, g_valid, gr, g_data_out, g_last, "sb_g");
      mon_ch(2, b_valid, br, b_data_out, b_last, "sb_b");
      if (pv && pixel_ready) begin
        sq[0].push_back({exp_cnt == NPIX - 1, pix[23:16]});
        sq[1].push_back({exp_cnt == NPIX - 1, pix[15:8]});
        sq[2].push_back({exp_cnt == NPIX - 1, pix[7:0]});
        exp_cnt = exp_cnt == NPIX - 1 ? 0 : exp_cnt + 1;
      end
    end
  end
  initial begin
    reset_n = 1'b0;
    pv = 1'b0;
    pix = '0;
    rr = 1'b1;
    gr = 1'b1;
    br = 1'b1;
    #1 chk_idle("por");
    @(negedge clk);
    reset_n = 1'b1;
    #2 chk("por_pixel_ready", pixel_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pix = pat(i);
      pv = 1'b1;
      #2 chk("stream_ready", pixel_ready, 1);
      if (i > 0) chk("stream_latency", r_data_out, 3 * (i - 1) + 1);
    end
    @(negedge clk);
    pv = 1'b0;
    #2 chk("stream_r_last", r_last, 1);
    chk("stream_g_last", g_last, 1);
    chk("stream_b_last", b_last, 1);
    chk("stream_r_data8", r_data_out, 8'h16);
    chk("stream_fd_early", frame_done, 0);
    @(negedge clk);
    #2 chk("stream_fd_pulse", frame_done, 1);
    chk("stream_fd_cnt", fd_cnt, 1);
    @(negedge clk);
    #2 chk("stream_fd_end", frame_done, 0);
    @(negedge clk);
    gr = 1'b0;
    pv = 1'b1;
    pix = 24'h112233;
    #2 chk("bp_ready_first", pixel_ready, 1);
    @(negedge clk);
    pix = 24'h445566;
    #2 chk("bp_ready_low", pixel_ready, 0);
    chk("bp_g_data", g_data_out, 8'h22);
    chk("bp_r_valid", r_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2 chk("bp_hold_ready", pixel_ready, 0);
      chk("bp_hold_g_data", g_data_out, 8'h22);
      chk("bp_hold_g_valid", g_valid, 1);
      chk("bp_r_idle", r_valid, 0);
      chk("bp_b_idle", b_valid, 0);
    end
    @(negedge clk);
    gr = 1'b1;
    #2 chk("bp_release_ready", pixel_ready, 1);
    @(negedge clk);
    pv = 1'b0;
    #2 chk("bp_r_next", r_data_out, 8'h44);
    chk("bp_g_next", g_data_out, 8'h55);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pix = pat(10 + i);
      pv = 1'b1;
    end
    @(negedge clk);
    pix = 24'h778899;
    @(negedge clk);
    pv = 1'b0;
    br = 1'b0;
    #2 chk("skew_r_last", r_last, 1);
    chk("skew_b_last", b_last, 1);
    chk("skew_b_valid", b_valid, 1);
    @(negedge clk);
    #2 chk("skew_r_drained", r_valid, 0);
    chk("skew_g_drained", g_valid, 0);
    chk("skew_b_held", b_data_out, 8'h99);
    chk("skew_fd_wait1", frame_done, 0);
    @(negedge clk);
    #2 chk("skew_fd_wait2", frame_done, 0);
    @(negedge clk);
    br = 1'b1;
    pv = 1'b1;
    pix = 24'hA1B2C3;
    #2 chk("skew_next_ready", pixel_ready, 1);
    chk("skew_fd_wait3", frame_done, 0);
    @(negedge clk);
    pv = 1'b0;
    #2 chk("skew_fd_pulse", frame_done, 1);
    chk("skew_next_last", r_last, 0);
    chk("skew_next_data", r_data_out, 8'hA1);
    @(negedge clk);
    #2 chk("skew_fd_end", frame_done, 0);
    chk("skew_fd_cnt", fd_cnt, 2);
    @(negedge clk);
    pix = 24'hAABBCC;
    pv = 1'b1;
    @(negedge clk);
    pv = 1'b0;
    #2 chk("bgr_r", x_r, 8'hCC);
    chk("bgr_g", x_g, 8'hBB);
    chk("bgr_b", x_b, 8'hAA);
    chk("rgb_r", r_data_out, 8'hAA);
    @(negedge clk);
    gr = 1'b0;
    pix = 24'h5A5A5A;
    pv = 1'b1;
    @(negedge clk);
    pv = 1'b0;
    #3 reset_n = 1'b0;
    #1 chk_idle("mid_rst");
    for (int c = 0; c < 3; c++) sq[c].delete();
    exp_cnt = 0;
    gr = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #2 chk("rst_release_ready", pixel_ready, 1);
    base = fd_cnt;
    sent = 0;
    for (int k = 0; k < 4000 && sent < 3 * NPIX; k++) begin
      @(negedge clk);
      rr = $urandom_range(0, 3) != 0;
      gr = $urandom_range(0, 3) != 0;
      br = $urandom_range(0, 3) != 0;
      pv = $urandom_range(0, 2) != 0;
      pix = 24'($urandom);
      #2 if (pv && pixel_ready) sent++;
    end
    @(negedge clk);
    pv = 1'b0;
    rr = 1'b1;
    gr = 1'b1;
    br = 1'b1;
    for (int k = 0; k < 20 && (sq[0].size() + sq[1].size() + sq[2].size()) != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 chk("rand_sent", sent, 3 * NPIX);
    chk("rand_drained", sq[0].size() + sq[1].size() + sq[2].size(), 0);
    chk("rand_frames", fd_cnt - base, 3);
    @(negedge clk);
    pix = 24'h010101;
    pv = 1'b1;
    @(negedge clk);
    pv = 1'b0;
    #2 chk("wrap_valid", r_valid, 1);
    chk("wrap_last", r_last, 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
